// File: rtl/hazard_scoreboard_fwd_pkg.sv
// Shared types and helpers for the hazard scoreboard: the shadow-entry record,
// the register-file select code and the select-width function.
// No ports; imported by hazard_src_match and hazard_scoreboard_fwd.
package hazard_scoreboard_fwd_pkg;

    // fwd_sel value meaning "take the operand from the register file".
    localparam int SEL_RF = 0;

    // Widest register index the shadow entry can hold. rd values are
    // zero-extended into this field, so any REG_AW up to this width works.
    localparam int RD_MAX_W = 8;

    // One in-flight writer tracked behind D.
    typedef struct packed {
        logic                v;   // entry holds a real writer of a non-zero rd
        logic [RD_MAX_W-1:0] rd;  // destination register (zero-extended)
        logic                ld;  // writer is a load (no result while in E)
    } shadow_ent_t;

    // Width of a forwarding select: codes 0..stages.
    function automatic int sel_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-operand hazard check: finds the youngest in-flight writer of one source
// register and returns the bypass select or a hazard.
// Combinational, zero latency; no flow control (pure function of its inputs).
// Ports: src/rd_en (source index and read-enable), ents (shadow pipe, index 0 = E),
//        sel (0 = register file, k+1 = stage k), hazard (operand not yet obtainable).
module hazard_src_match
    import hazard_scoreboard_fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int STAGES = 3,
    parameter int FWD_EN = 1,
    parameter int SELW   = 2
) (
    input  logic [REG_AW-1:0]        src,
    input  logic                     rd_en,
    input  shadow_ent_t [STAGES-1:0] ents,
    output logic [SELW-1:0]          sel,
    output logic                     hazard
);

    logic [RD_MAX_W-1:0] src_ext;
    logic                src_live;

    assign src_ext  = RD_MAX_W'(src);
    assign src_live = rd_en && (src != '0);

    // The WB entry is deliberately never compared: the register file writes
    // in the first half of the cycle, so D already reads the new value.
    logic wb_unused;
    assign wb_unused = ^ents[STAGES-1];

    // Scan from the oldest checked stage towards E so that the youngest
    // matching writer is the one whose assignment sticks.
    always_comb begin
        sel    = SELW'(SEL_RF);
        hazard = 1'b0;
        for (int k = STAGES - 2; k >= 0; k--) begin
            if (src_live && ents[k].v && (ents[k].rd == src_ext)) begin
                if (FWD_EN != 0) begin
                    // A load only has data once it has left E.
                    if (!ents[k].ld || (k >= 1)) begin
                        sel    = SELW'(k + 1);
                        hazard = 1'b0;
                    end else begin
                        sel    = SELW'(SEL_RF);
                        hazard = 1'b1;
                    end
                end else begin
                    sel    = SELW'(SEL_RF);
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_fwd.sv
// Hazard unit beside decode: shadow destination pipe of in-flight writers,
// stall/flush generation, per-operand bypass selects, saturating perf counters.
// Outputs are combinational (zero latency); a stall holds F/D until the blocking
// writer advances, a jump in E overrides any stall and flushes D and E.
// Ports: clk, reset_E (async, active-high); D-stage instruction fields
//        (valid_D, rd_we_D, rd_D, is_load_D, rs1/rs2 read-enables and indices);
//        jumping; stall_F/stall_D/flush_D/flush_E; fwd_sel1/fwd_sel2;
//        stall_cnt/flush_cnt.
module hazard_scoreboard_fwd
    import hazard_scoreboard_fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int STAGES = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset_E,
    input  logic                          valid_D,
    input  logic                          rd_we_D,
    input  logic [REG_AW-1:0]             rd_D,
    input  logic                          is_load_D,
    input  logic                          rs1_rd_D,
    input  logic                          rs2_rd_D,
    input  logic [REG_AW-1:0]             rs1_D,
    input  logic [REG_AW-1:0]             rs2_D,
    input  logic                          jumping,
    output logic                          stall_F,
    output logic                          stall_D,
    output logic                          flush_D,
    output logic                          flush_E,
    output logic [sel_width(STAGES)-1:0]  fwd_sel1,
    output logic [sel_width(STAGES)-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int SELW = sel_width(STAGES);

    // Shadow pipe: ents[0] mirrors E, ents[STAGES-1] mirrors WB.
    shadow_ent_t [STAGES-1:0] ents;
    shadow_ent_t              ent_in;

    logic hazard1;
    logic hazard2;
    logic hazard;

    hazard_src_match #(
        .REG_AW (REG_AW),
        .STAGES (STAGES),
        .FWD_EN (FWD_EN),
        .SELW   (SELW)
    ) u_match_rs1 (
        .src    (rs1_D),
        .rd_en  (rs1_rd_D),
        .ents   (ents),
        .sel    (fwd_sel1),
        .hazard (hazard1)
    );

    hazard_src_match #(
        .REG_AW (REG_AW),
        .STAGES (STAGES),
        .FWD_EN (FWD_EN),
        .SELW   (SELW)
    ) u_match_rs2 (
        .src    (rs2_D),
        .rd_en  (rs2_rd_D),
        .ents   (ents),
        .sel    (fwd_sel2),
        .hazard (hazard2)
    );

    // The instruction in D during a jump is wrong-path, so it never stalls.
    assign hazard  = (hazard1 || hazard2) && valid_D && !jumping;

    assign stall_F = hazard;
    assign stall_D = hazard;
    assign flush_E = hazard || jumping;
    // While reset is held the D register is being cleared anyway; keep the
    // flush request quiet so the pipeline sees a clean reset state.
    assign flush_D = jumping && !reset_E;

    // A stalled or wrong-path D instruction enters E as a bubble, so it must
    // not be recorded as a writer. x0 writes are never tracked.
    always_comb begin
        ent_in    = '0;
        ent_in.v  = valid_D && rd_we_D && (rd_D != '0) && !hazard && !jumping;
        ent_in.rd = RD_MAX_W'(rd_D);
        ent_in.ld = is_load_D;
    end

    always_ff @(posedge clk or posedge reset_E) begin
        if (reset_E) begin
            ents <= '0;
        end else begin
            ents[0] <= ent_in;
            for (int k = 1; k < STAGES; k++) begin
                ents[k] <= ents[k-1];
            end
        end
    end

    // Saturating performance counters: they stick at all-ones.
    always_ff @(posedge clk or posedge reset_E) begin
        if (reset_E) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_D && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (jumping && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// Self-checking bench: two instances (bypass on / bypass off, STAGES=3, 4-bit
// counters) share one input stream; each is compared against an age-based
// model of in-flight writers, with directed scenarios followed by random traffic.
module tb_hazard_scoreboard_fwd;

    localparam int STG = 3;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       reset_E;
    logic       valid_D, rd_we_D, is_load_D, rs1_rd_D, rs2_rd_D, jumping;
    logic [4:0] rd_D, rs1_D, rs2_D;

    logic          f_stall_F, f_stall_D, f_flush_D, f_flush_E;
    logic [1:0]    f_sel1, f_sel2;
    logic [CW-1:0] f_scnt, f_fcnt;
    logic          n_stall_F, n_stall_D, n_flush_D, n_flush_E;
    logic [1:0]    n_sel1, n_sel2;
    logic [CW-1:0] n_scnt, n_fcnt;

    always #5 clk = ~clk;

    hazard_scoreboard_fwd #(.REG_AW(5), .STAGES(STG), .FWD_EN(1), .CNT_W(CW)) dut_f (
        .clk(clk), .reset_E(reset_E), .valid_D(valid_D), .rd_we_D(rd_we_D),
        .rd_D(rd_D), .is_load_D(is_load_D), .rs1_rd_D(rs1_rd_D), .rs2_rd_D(rs2_rd_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .jumping(jumping),
        .stall_F(f_stall_F), .stall_D(f_stall_D), .flush_D(f_flush_D), .flush_E(f_flush_E),
        .fwd_sel1(f_sel1), .fwd_sel2(f_sel2), .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
    );

    hazard_scoreboard_fwd #(.REG_AW(5), .STAGES(STG), .FWD_EN(0), .CNT_W(CW)) dut_n (
        .clk(clk), .reset_E(reset_E), .valid_D(valid_D), .rd_we_D(rd_we_D),
        .rd_D(rd_D), .is_load_D(is_load_D), .rs1_rd_D(rs1_rd_D), .rs2_rd_D(rs2_rd_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .jumping(jumping),
        .stall_F(n_stall_F), .stall_D(n_stall_D), .flush_D(n_flush_D), .flush_E(n_flush_E),
        .fwd_sel1(n_sel1), .fwd_sel2(n_sel2), .stall_cnt(n_scnt), .flush_cnt(n_fcnt)
    );

    // ---------------- reference model ----------------
    // Each accepted writer is remembered with its age (cycles since leaving D).
    typedef struct {
        int rd;
        bit ld;
        int age;
    } wr_t;
    typedef wr_t wq_t[$];

    wq_t q_f, q_n;
    int  sc_f, fc_f, sc_n, fc_n;
    int  total = 0;
    int  bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Youngest writer of s still before WB decides the operand.
    function automatic void model_src(input wq_t q, input bit fwd, input int s,
                                      input bit en, output int sel, output bit haz);
        int best;
        bit bld;
        best = -1;
        bld  = 1'b0;
        sel  = 0;
        haz  = 1'b0;
        if (en && s != 0) begin
            foreach (q[i]) begin
                if (q[i].rd == s && q[i].age <= STG - 2 && (best < 0 || q[i].age < best)) begin
                    best = q[i].age;
                    bld  = q[i].ld;
                end
            end
            if (best >= 0) begin
                if (!fwd)                   haz = 1'b1;
                else if (bld && best == 0)  haz = 1'b1;
                else                        sel = best + 1;
            end
        end
    endfunction

    function automatic void eval_inst(input wq_t q, input bit fwd,
                                      output int s1, output int s2, output bit hz);
        bit h1, h2;
        model_src(q, fwd, int'(rs1_D), rs1_rd_D, s1, h1);
        model_src(q, fwd, int'(rs2_D), rs2_rd_D, s2, h2);
        hz = (h1 || h2) && valid_D && !jumping;
    endfunction

    function automatic wq_t advance(input wq_t q, input bit hz);
        wq_t r;
        foreach (q[i]) begin
            if (q[i].age + 1 < STG) r.push_back('{rd: q[i].rd, ld: q[i].ld, age: q[i].age + 1});
        end
        if (!hz && !jumping && valid_D && rd_we_D && rd_D != 0)
            r.push_back('{rd: int'(rd_D), ld: is_load_D, age: 0});
        return r;
    endfunction

    task automatic model_reset();
        q_f.delete();
        q_n.delete();
        sc_f = 0; fc_f = 0; sc_n = 0; fc_n = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit we, input int rd, input bit ld,
                         input bit e1, input bit e2, input int s1, input int s2, input bit j);
        valid_D = v; rd_we_D = we; rd_D = 5'(rd); is_load_D = ld;
        rs1_rd_D = e1; rs2_rd_D = e2; rs1_D = 5'(s1); rs2_D = 5'(s2); jumping = j;
        #2;
    endtask

    task automatic check_all();
        int s1, s2;
        bit hz;
        int fd;
        fd = int'(jumping && !reset_E);
        eval_inst(q_f, 1'b1, s1, s2, hz);
        check_eq("f_stall_F", int'(f_stall_F), int'(hz));
        check_eq("f_stall_D", int'(f_stall_D), int'(hz));
        check_eq("f_flush_E", int'(f_flush_E), int'(hz || jumping));
        check_eq("f_flush_D", int'(f_flush_D), fd);
        check_eq("f_sel1", int'(f_sel1), s1);
        check_eq("f_sel2", int'(f_sel2), s2);
        check_eq("f_stall_cnt", int'(f_scnt), sc_f);
        check_eq("f_flush_cnt", int'(f_fcnt), fc_f);
        eval_inst(q_n, 1'b0, s1, s2, hz);
        check_eq("n_stall_F", int'(n_stall_F), int'(hz));
        check_eq("n_stall_D", int'(n_stall_D), int'(hz));
        check_eq("n_flush_E", int'(n_flush_E), int'(hz || jumping));
        check_eq("n_flush_D", int'(n_flush_D), fd);
        check_eq("n_sel1", int'(n_sel1), s1);
        check_eq("n_sel2", int'(n_sel2), s2);
        check_eq("n_stall_cnt", int'(n_scnt), sc_n);
        check_eq("n_flush_cnt", int'(n_fcnt), fc_n);
    endtask

    task automatic tick();
        int s1, s2;
        bit hf, hn;
        eval_inst(q_f, 1'b1, s1, s2, hf);
        eval_inst(q_n, 1'b0, s1, s2, hn);
        @(posedge clk);
        q_f = advance(q_f, hf);
        q_n = advance(q_n, hn);
        if (hf && sc_f < CMAX) sc_f++;
        if (hn && sc_n < CMAX) sc_n++;
        if (jumping && fc_f < CMAX) fc_f++;
        if (jumping && fc_n < CMAX) fc_n++;
        @(negedge clk);
    endtask

    task automatic step(input bit v, input bit we, input int rd, input bit ld,
                        input bit e1, input bit e2, input int s1, input int s2, input bit j);
        drive(v, we, rd, ld, e1, e2, s1, s2, j);
        check_all();
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_E = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        // Reset state: no stall, flush_E follows jumping, flush_D held low.
        check_eq("rst_stall", int'(f_stall_D), 0);
        check_eq("rst_flushE", int'(f_flush_E), 1);
        check_eq("rst_flushD", int'(f_flush_D), 0);
        check_eq("rst_cnt", int'(f_fcnt), 0);
        check_all();
        jumping = 1'b0;
        reset_E = 1'b0;
        @(negedge clk);

        // Load-use on rs2: one stall cycle, then bypass from stage 1.
        step(1, 1, 7, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 8, 0, 0, 1, 0, 7, 0);
        check_all();
        check_eq("lu_stall", int'(f_stall_D), 1);
        check_eq("lu_flushE", int'(f_flush_E), 1);
        tick();
        check_all();
        check_eq("lu_stall2", int'(f_stall_D), 0);
        check_eq("lu_sel2", int'(f_sel2), 2);
        check_eq("lu_cnt", int'(f_scnt), 1);
        tick();

        // Jump while a load-use hazard is pending: the jump wins.
        step(1, 1, 10, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 11, 0, 1, 0, 10, 0, 1);
        check_all();
        check_eq("jmp_stall", int'(f_stall_D), 0);
        check_eq("jmp_flushD", int'(f_flush_D), 1);
        check_eq("jmp_flushE", int'(f_flush_E), 1);
        tick();
        drive(1, 0, 0, 0, 1, 0, 11, 0, 0);
        check_all();
        check_eq("jmp_cnt", int'(f_fcnt), 1);
        check_eq("jmp_nostale", int'(f_sel1), 0);
        tick();

        // Youngest writer wins; identical sources give identical selects.
        step(1, 1, 9, 0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 9, 9, 0);
        check_all();
        check_eq("yw_sel1", int'(f_sel1), 1);
        check_eq("yw_sel2", int'(f_sel2), 1);
        tick();

        // RAW ALU bypass: sel walks 1, 2, then register file.
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 5, 0, 0);
        check_all();
        check_eq("raw_sel_e", int'(f_sel1), 1);
        tick();
        drive(1, 0, 0, 0, 1, 0, 5, 0, 0);
        check_all();
        check_eq("raw_sel_m", int'(f_sel1), 2);
        tick();
        drive(1, 0, 0, 0, 1, 0, 5, 0, 0);
        check_all();
        check_eq("raw_sel_wb", int'(f_sel1), 0);
        tick();

        // x0 writes are never tracked.
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
        check_all();
        check_eq("x0_nstall", int'(n_stall_D), 0);
        tick();

        // Reset asserted asynchronously in the middle of a load-use stall.
        step(1, 1, 12, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 12, 0, 0);
        check_all();
        check_eq("mr_pre", int'(f_stall_D), 1);
        reset_E = 1'b1;
        #1;
        check_eq("mr_stall", int'(f_stall_D), 0);
        check_eq("mr_nstall", int'(n_stall_D), 0);
        check_eq("mr_fcnt", int'(f_scnt), 0);
        check_eq("mr_ncnt", int'(n_scnt), 0);
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset_E = 1'b0;

        // Back-to-back dependent ALU ops: no stall with bypass, repeated
        // 2-cycle stalls without it, driving the 4-bit counter into saturation.
        for (int i = 0; i < 40; i++) step(1, 1, 3, 0, 1, 0, 3, 0, 0);
        check_eq("sat_n", int'(n_scnt), CMAX);
        check_eq("sat_f", int'(f_scnt), 0);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
